// File: rtl/controle_busca_pkg.sv
// Shared definitions for the fetch controller, the instruction mux and the bench:
// state encodings and the default quantum width.
package controle_busca_pkg;

  localparam int QUANTUM_W_DEF = 16;

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    EXEC   = 2'd1,
    PREEMP = 2'd2,
    ESPERA = 2'd3
  } estado_t;

  // Instruction-mux select for a given state: only BOOT fetches from the BIOS.
  function automatic logic controle_de(input estado_t e);
    return (e != BOOT);
  endfunction

endpackage

// File: rtl/controle_busca_contador_quantum.sv
// Quantum counter: latches the slice length on load, counts retired instructions
// and flags the last instruction of the slice.
module contador_quantum #(
  parameter int QUANTUM_W = controle_busca_pkg::QUANTUM_W_DEF
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 limpa,
  input  logic                 carga,
  input  logic [QUANTUM_W-1:0] limite,
  input  logic                 habilita,
  output logic [QUANTUM_W-1:0] contagem,
  output logic                 terminal
);

  logic [QUANTUM_W-1:0] contagem_q, contagem_d;
  logic [QUANTUM_W-1:0] limite_q, limite_d;

  always_comb begin
    contagem_d = contagem_q;
    limite_d   = limite_q;
    if (limpa) begin
      contagem_d = '0;
      limite_d   = '0;
    end else if (carga) begin
      contagem_d = '0;
      limite_d   = limite;
    // A zero limit means preemption is off; stopping at the limit keeps the count from wrapping.
    end else if (habilita && (limite_q != '0) && (contagem_q != limite_q)) begin
      contagem_d = contagem_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      contagem_q <= '0;
      limite_q   <= '0;
    end else begin
      contagem_q <= contagem_d;
      limite_q   <= limite_d;
    end
  end

  assign contagem = contagem_q;
  assign terminal = (limite_q != '0) && (contagem_q == (limite_q - 1'b1));

endmodule

// File: rtl/controle_busca.sv
// Instruction-fetch controller: BIOS boot, execution and optional quantum preemption.
// Preemption (PREEMP/ESPERA and the counter) is built only with CONTROLE_BUSCA_PREEMPCAO_EN.
module controle_busca #(
  parameter int QUANTUM_W = controle_busca_pkg::QUANTUM_W_DEF
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 bios_fim,
  input  logic                 avanca_pc,
  input  logic [QUANTUM_W-1:0] quantum,
  input  logic                 troca_ok,
  input  logic                 retorna_bios,
  output logic                 controle,
  output logic                 flag_temporizador,
  output logic [1:0]           estado,
  output logic [QUANTUM_W-1:0] contagem
);

  import controle_busca_pkg::*;

  estado_t estado_q, estado_d;
  logic    controle_q, controle_d;

`ifdef CONTROLE_BUSCA_PREEMPCAO_EN
  logic flag_q, flag_d;
  logic carga, habilita, limpa, terminal;

  contador_quantum #(.QUANTUM_W(QUANTUM_W)) u_contador (
    .clock    (clock),
    .reset    (reset),
    .limpa    (limpa),
    .carga    (carga),
    .limite   (quantum),
    .habilita (habilita),
    .contagem (contagem),
    .terminal (terminal)
  );

  always_comb begin
    estado_d = estado_q;
    carga    = 1'b0;
    habilita = 1'b0;
    limpa    = 1'b0;
    if (retorna_bios) begin
      estado_d = BOOT;
      limpa    = 1'b1;
    end else begin
      case (estado_q)
        BOOT: if (bios_fim) begin
          estado_d = EXEC;
          carga    = 1'b1;
        end
        EXEC: begin
          habilita = avanca_pc;
          if (avanca_pc && terminal) estado_d = PREEMP;
        end
        PREEMP: if (avanca_pc) estado_d = ESPERA;
        ESPERA: if (troca_ok) begin
          estado_d = EXEC;
          carga    = 1'b1;
        end
        default: estado_d = BOOT;
      endcase
    end
    controle_d = controle_de(estado_d);
    flag_d     = (estado_d == PREEMP);
  end

  always_ff @(posedge clock) begin
    if (reset) flag_q <= 1'b0;
    else       flag_q <= flag_d;
  end

  assign flag_temporizador = flag_q;
`else
  // Without preemption these inputs have no effect on the controller.
  logic unused_entradas;
  assign unused_entradas = ^{quantum, troca_ok, avanca_pc};

  always_comb begin
    estado_d = estado_q;
    if (retorna_bios) begin
      estado_d = BOOT;
    end else begin
      case (estado_q)
        BOOT:    if (bios_fim) estado_d = EXEC;
        EXEC:    estado_d = EXEC;
        default: estado_d = BOOT;
      endcase
    end
    controle_d = controle_de(estado_d);
  end

  assign flag_temporizador = 1'b0;
  assign contagem          = '0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      estado_q   <= BOOT;
      controle_q <= 1'b0;
    end else begin
      estado_q   <= estado_d;
      controle_q <= controle_d;
    end
  end

  assign controle = controle_q;
  assign estado   = estado_q;

endmodule

// File: tb/tb_controle_busca.sv
// Self-checking bench for controle_busca: directed scenarios followed by random
// stimulus, all checked every cycle against a behavioural model of the rules.
module tb_controle_busca;

  import controle_busca_pkg::*;

  localparam int QW = QUANTUM_W_DEF;
`ifdef CONTROLE_BUSCA_PREEMPCAO_EN
  localparam bit EN = 1'b1;
`else
  localparam bit EN = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          bios_fim = 1'b0;
  logic          avanca_pc = 1'b0;
  logic [QW-1:0] quantum = '0;
  logic          troca_ok = 1'b0;
  logic          retorna_bios = 1'b0;
  logic          controle;
  logic          flag_temporizador;
  logic [1:0]    estado;
  logic [QW-1:0] contagem;

  int total = 0;
  int bad = 0;

  // Reference model state
  int          m_st = 0;
  int unsigned m_cont = 0;
  int unsigned m_qlat = 0;

  controle_busca #(.QUANTUM_W(QW)) dut (
    .clock             (clock),
    .reset             (reset),
    .bios_fim          (bios_fim),
    .avanca_pc         (avanca_pc),
    .quantum           (quantum),
    .troca_ok          (troca_ok),
    .retorna_bios      (retorna_bios),
    .controle          (controle),
    .flag_temporizador (flag_temporizador),
    .estado            (estado),
    .contagem          (contagem)
  );

  always #5 clock = ~clock;

  task automatic verifica(input string tag, input logic [63:0] obs, input logic [63:0] esp);
    total++;
    assert (obs === esp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, esp);
    end
  endtask

  // One clock edge of the rules: 0=BOOT 1=EXEC 2=PREEMP 3=ESPERA.
  task automatic modelo();
    if (reset || retorna_bios) begin
      m_st   = 0;
      m_cont = 0;
      if (reset) m_qlat = 0;
    end else if (m_st == 0) begin
      if (bios_fim) begin
        m_st = 1; m_cont = 0; m_qlat = quantum;
      end
    end else if (m_st == 1) begin
      if (EN && avanca_pc && m_qlat != 0) begin
        m_cont = m_cont + 1;
        if (m_cont == m_qlat) m_st = 2;
      end
    end else if (m_st == 2) begin
      if (avanca_pc) m_st = 3;
    end else begin
      if (troca_ok) begin
        m_st = 1; m_cont = 0; m_qlat = quantum;
      end
    end
  endtask

  task automatic ciclo();
    @(posedge clock);
    modelo();
    #1;
    verifica("estado", 64'(estado), 64'(m_st));
    verifica("controle", 64'(controle), 64'(m_st != 0));
    verifica("flag", 64'(flag_temporizador), 64'(m_st == 2));
    verifica("contagem", 64'(contagem), 64'(m_cont));
  endtask

  task automatic ciclos(input int n);
    for (int i = 0; i < n; i++) ciclo();
  endtask

  initial begin
    // Reset values
    reset = 1'b1; quantum = 16'd3;
    ciclos(2);
    $display("step reset: estado=%0d controle=%0b flag=%0b contagem=%0d", estado, controle, flag_temporizador, contagem);
    verifica("reset_estado", 64'(estado), 64'(BOOT));
    verifica("reset_contagem", 64'(contagem), 64'd0);

    // BIOS runs cycles 1..4, bios_fim at cycle 5
    reset = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      ciclo();
      verifica("boot_controle", 64'(controle), 64'd0);
    end
    bios_fim = 1'b1;
    ciclo();
    bios_fim = 1'b0;
    $display("step bios_fim: estado=%0d controle=%0b", estado, controle);
    verifica("exec_controle", 64'(controle), 64'd1);
    verifica("exec_estado", 64'(estado), 64'(EXEC));

    // quantum=3, continuous retires
    avanca_pc = 1'b1;
    ciclos(3);
    avanca_pc = 1'b0;
    $display("step quantum3: estado=%0d flag=%0b contagem=%0d", estado, flag_temporizador, contagem);
    verifica("q3_estado", 64'(estado), EN ? 64'(PREEMP) : 64'(EXEC));
    verifica("q3_flag", 64'(flag_temporizador), 64'(EN));
    verifica("q3_contagem", 64'(contagem), EN ? 64'd3 : 64'd0);

    // Timer instruction held until consumed; troca_ok ignored here
    troca_ok = 1'b1;
    for (int c = 0; c < 4; c++) begin
      ciclo();
      verifica("preemp_hold_flag", 64'(flag_temporizador), 64'(EN));
    end
    troca_ok = 1'b0;
    avanca_pc = 1'b1;
    ciclo();
    avanca_pc = 1'b0;
    $display("step pulse: estado=%0d flag=%0b", estado, flag_temporizador);
    verifica("espera_estado", 64'(estado), EN ? 64'(ESPERA) : 64'(EXEC));
    verifica("espera_flag", 64'(flag_temporizador), 64'd0);
    ciclos(2);

    // Context switch done with a new quantum of 5
    quantum = 16'd5; troca_ok = 1'b1;
    ciclo();
    troca_ok = 1'b0;
    verifica("relatch_contagem", 64'(contagem), 64'd0);
    verifica("relatch_estado", 64'(estado), 64'(EXEC));
    avanca_pc = 1'b1;
    ciclos(4);
    verifica("q5_before", 64'(flag_temporizador), 64'd0);
    ciclo();
    avanca_pc = 1'b0;
    $display("step quantum5: estado=%0d flag=%0b contagem=%0d", estado, flag_temporizador, contagem);
    verifica("q5_flag", 64'(flag_temporizador), 64'(EN));
    verifica("q5_contagem", 64'(contagem), EN ? 64'd5 : 64'd0);

    // Soft reboot has priority over troca_ok and bios_fim
    retorna_bios = 1'b1; troca_ok = 1'b1; bios_fim = 1'b1; avanca_pc = 1'b1;
    ciclo();
    retorna_bios = 1'b0; troca_ok = 1'b0; bios_fim = 1'b0; avanca_pc = 1'b0;
    $display("step retorna_bios: estado=%0d controle=%0b flag=%0b", estado, controle, flag_temporizador);
    verifica("reboot_estado", 64'(estado), 64'(BOOT));
    verifica("reboot_controle", 64'(controle), 64'd0);
    verifica("reboot_flag", 64'(flag_temporizador), 64'd0);

    // quantum=0: 1000 retires, never preempted
    quantum = '0; bios_fim = 1'b1;
    ciclo();
    bios_fim = 1'b0; avanca_pc = 1'b1; quantum = 16'd2;
    ciclos(1000);
    avanca_pc = 1'b0;
    $display("step quantum0: estado=%0d flag=%0b contagem=%0d", estado, flag_temporizador, contagem);
    verifica("q0_estado", 64'(estado), 64'(EXEC));
    verifica("q0_contagem", 64'(contagem), 64'd0);

    // quantum=1 preempts after one retire; reset together with retorna_bios in PREEMP
    retorna_bios = 1'b1;
    ciclo();
    retorna_bios = 1'b0; quantum = 16'd1; bios_fim = 1'b1;
    ciclo();
    bios_fim = 1'b0; avanca_pc = 1'b1;
    ciclo();
    avanca_pc = 1'b0;
    verifica("q1_flag", 64'(flag_temporizador), 64'(EN));
    reset = 1'b1; retorna_bios = 1'b1;
    ciclo();
    reset = 1'b0; retorna_bios = 1'b0;
    $display("step reset_preemp: estado=%0d flag=%0b contagem=%0d", estado, flag_temporizador, contagem);
    verifica("rst_flag", 64'(flag_temporizador), 64'd0);
    verifica("rst_estado", 64'(estado), 64'(BOOT));

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      reset        = ($urandom_range(0, 299) == 0);
      retorna_bios = ($urandom_range(0, 149) == 0);
      bios_fim     = ($urandom_range(0, 7) == 0);
      avanca_pc    = $urandom_range(0, 1) == 1;
      troca_ok     = ($urandom_range(0, 3) == 0);
      quantum      = ($urandom_range(0, 9) == 0) ? '0 : QW'($urandom_range(1, 6));
      ciclo();
    end
    $display("step random: 3000 cycles");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/controle_busca.md
CONTROLE_BUSCA -- requirements
Module: controle_busca

Interface
REQ-001 SHALL have parameter QUANTUM_W, default 16, giving the width of the quantum counter and of the quantum input.
REQ-002 SHALL have port clock, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port bios_fim, input, 1 bit: BIOS finished; hand fetch over to instruction memory.
REQ-005 SHALL have port avanca_pc, input, 1 bit: the processor consumed one fetched instruction this cycle.
REQ-006 SHALL have port quantum, input, QUANTUM_W bits: time slice in retired instructions; 0 disables preemption.
REQ-007 SHALL have port troca_ok, input, 1 bit: the OS finished the context switch after preemption.
REQ-008 SHALL have port retorna_bios, input, 1 bit: soft reboot request.
REQ-009 SHALL have port controle, output, 1 bit: instruction-mux select; 0 = BIOS, 1 = instruction memory.
REQ-010 SHALL have port flag_temporizador, output, 1 bit: instruction mux passes the timer instruction.
REQ-011 SHALL have port estado, output, 2 bits: current state encoding.
REQ-012 SHALL have port contagem, output, QUANTUM_W bits: instructions retired in the current slice.

Function
REQ-013 SHALL have states BOOT=0, EXEC=1, PREEMP=2 and ESPERA=3, with all outputs registered and a pure function of the state plus the counter.
REQ-014 In BOOT, SHALL drive controle=0 and flag_temporizador=0, and SHALL move to EXEC on the cycle after bios_fim=1.
REQ-015 On entry to EXEC, SHALL latch quantum into an internal register qlat and clear contagem to 0.
REQ-016 In EXEC, SHALL drive controle=1 and flag_temporizador=0, and SHALL increment contagem on each cycle with avanca_pc=1 when qlat!=0.
REQ-017 In EXEC with qlat!=0, when avanca_pc=1 and contagem==qlat-1, SHALL go to PREEMP next cycle with contagem=qlat.
REQ-018 In EXEC with qlat=0, contagem SHALL hold 0 and preemption SHALL never occur.
REQ-019 In PREEMP, SHALL drive controle=1 and flag_temporizador=1 until a cycle with avanca_pc=1, then go to ESPERA.
REQ-020 In ESPERA, SHALL drive controle=1 and flag_temporizador=0, hold contagem, and go to EXEC (relatching quantum) on the cycle after troca_ok=1.
REQ-021 SHALL ignore troca_ok outside ESPERA and bios_fim outside BOOT.
REQ-022 SHALL give retorna_bios=1 in any state priority over every other input, moving to BOOT next cycle with contagem cleared.
REQ-023 SHALL never let contagem wrap; quantum=1 SHALL preempt after every retired instruction.

Reset
REQ-024 While reset=1 at a clock edge, SHALL force estado=BOOT, controle=0, flag_temporizador=0, contagem=0 and qlat=0.
REQ-025 SHALL give reset priority over retorna_bios and all other inputs.
REQ-026 Reset asserted in PREEMP SHALL drop flag_temporizador on the next edge.

Configuration
REQ-027 SHALL recognise the macro CONTROLE_BUSCA_PREEMPCAO_EN.
REQ-028 With CONTROLE_BUSCA_PREEMPCAO_EN defined, SHALL implement the full four-state behaviour above.
REQ-029 Without CONTROLE_BUSCA_PREEMPCAO_EN, SHALL remove PREEMP, ESPERA and the counter logic, tie flag_temporizador=0 and contagem=0, and ignore quantum and troca_ok.
REQ-030 Without CONTROLE_BUSCA_PREEMPCAO_EN, SHALL keep the BOOT/EXEC behaviour and retorna_bios unchanged.

Structure
REQ-031 SHALL take the state encodings (BOOT, EXEC, PREEMP, ESPERA) and the QUANTUM_W default from a shared package, also used by the instruction mux and the bench.
REQ-032 SHALL place the quantum counter in one sub-module, contador_quantum (load, enable, terminal-count flag); the state machine stays in controle_busca.

Verification
REQ-033 Reset then bios_fim=1 at cycle 5 -> SHALL give controle=0 through cycle 5, and controle=1 with estado=1 from cycle 6.
REQ-034 quantum=3 and avanca_pc=1 continuously in EXEC -> SHALL set flag_temporizador=1 on the edge after the 3rd retire, with contagem=3 and estado=2.
REQ-035 In PREEMP with avanca_pc held 0 for 4 cycles, then 1 -> SHALL keep flag=1 for those 4 cycles plus the pulse cycle, then estado=3.
REQ-036 ESPERA, troca_ok=1 with quantum changed to 5 -> SHALL give EXEC with contagem=0, then preemption after 5 retires.
REQ-037 quantum=0 with 1000 retires -> SHALL give flag_temporizador=0 and contagem=0 throughout.
REQ-038 retorna_bios=1 in PREEMP while troca_ok=1 and bios_fim=1 -> SHALL give BOOT, controle=0, flag=0; reset with retorna_bios -> reset values; both builds SHALL be run (with and without CONTROLE_BUSCA_PREEMPCAO_EN).
